// File: rtl/cr_lane_accumulator_pkg.sv
// Shared types for the correlated-random lane datapath: lane width selector, 32-bit limb with carry,
// accumulator job states and the lane-start (carry kill) mask builder.
package cr_lane_accumulator_pkg;

  typedef struct packed {
    logic is256;
    logic is128;
    logic is64;
  } width_t;

  typedef struct packed {
    logic        c;
    logic [31:0] w;
  } u32_w_c_t;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } acc_state_t;

  localparam int unsigned KILL_MAX = 64;

  // Bit i set means limb i starts a lane: its carry-in is the lane-start value, never the lower limb's carry.
  // Lane sizes are relative to the datapath: is256 spans the whole word, is128 splits it in half.
  function automatic logic [KILL_MAX-1:0] lane_kill(input width_t w, input int unsigned nlimb);
    logic [KILL_MAX-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < KILL_MAX; i++) begin
      if (i < nlimb) begin
        if (w.is256)      k[i] = (i == 0);
        else if (w.is128) k[i] = (i == 0) || (i == nlimb / 2);
        else if (w.is64)  k[i] = (i % 2 == 0);
        else              k[i] = 1'b1;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/cr_lane_addsub.sv
// Combinational lane-segmented adder/subtractor: limb ripple with carries killed at lane starts.
// Subtract adds the inverted operand with carry-in 1 at every lane start (two's complement per lane).
module cr_lane_addsub
  import cr_lane_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LIMB_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        width,
  input  logic              sub,
  output logic [DATA_W-1:0] sum
);

  localparam int unsigned NLIMB = DATA_W / LIMB_W;

  logic [KILL_MAX-1:0] kill_full;
  logic [NLIMB-1:0]    kill;

  assign kill_full = lane_kill(width_t'(width), NLIMB);
  assign kill      = kill_full[NLIMB-1:0];

  if (LIMB_W == 32) begin : g_u32
    always_comb begin
      u32_w_c_t    t;
      logic [31:0] bl;
      logic        c;
      sum = '0;
      c   = 1'b0;
      t   = '0;
      bl  = '0;
      for (int i = 0; i < int'(NLIMB); i++) begin
        bl = sub ? ~b[i*32 +: 32] : b[i*32 +: 32];
        t  = {1'b0, a[i*32 +: 32]} + {1'b0, bl} + {32'd0, (kill[i] ? sub : c)};
        sum[i*32 +: 32] = t.w;
        c  = t.c;
      end
    end
  end else begin : g_generic
    always_comb begin
      logic [LIMB_W:0]   t;
      logic [LIMB_W-1:0] bl;
      logic              c;
      sum = '0;
      c   = 1'b0;
      t   = '0;
      bl  = '0;
      for (int i = 0; i < int'(NLIMB); i++) begin
        bl = sub ? ~b[i*LIMB_W +: LIMB_W] : b[i*LIMB_W +: LIMB_W];
        t  = {1'b0, a[i*LIMB_W +: LIMB_W]} + {1'b0, bl} + {{LIMB_W{1'b0}}, (kill[i] ? sub : c)};
        sum[i*LIMB_W +: LIMB_W] = t[LIMB_W-1:0];
        c  = t[LIMB_W];
      end
    end
  end

endmodule

// File: rtl/cr_lane_accumulator.sv
// Job-based lane accumulator: sums/subtracts num_words PRNG words at 1 word/cycle, result valid the
// cycle after the last input handshake; input stalls outside ACC, result holds until out_ready_i.
module cr_lane_accumulator
  import cr_lane_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned LIMB_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        width_i,
  input  logic              sub_i,
  input  logic [CNT_W-1:0]  num_words_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  words_done_o
);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, sum;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [2:0]        width_q, width_d;
  logic              sub_q, sub_d;

  cr_lane_addsub #(
    .DATA_W (DATA_W),
    .LIMB_W (LIMB_W)
  ) u_addsub (
    .a     (acc_q),
    .b     (in_data_i),
    .width (width_q),
    .sub   (sub_q),
    .sum   (sum)
  );

  // The count only reaches the latched num, so an all-ones num never wraps before matching.
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    width_d     = width_q;
    sub_d       = sub_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          width_d = width_i;
          sub_d   = sub_i;
          num_d   = num_words_i;
          acc_d   = '0;
          cnt_d   = '0;
          if (num_words_i == '0) begin
            state_d     = OUT;
            out_data_d  = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid_i) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d     = OUT;
            out_data_d  = sum;
            out_valid_d = 1'b1;
          end
        end
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      num_q       <= '0;
      width_q     <= '0;
      sub_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      width_q     <= width_d;
      sub_q       <= sub_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign in_ready_o   = (state_q == ACC);
  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign words_done_o = cnt_q;

endmodule

// File: doc/cr_lane_accumulator.md
Name: cr_lane_accumulator

Overview:
- Streaming, lane-segmented accumulator that sums (or subtracts) a programmable number of 256-bit PRNG words into one correlated-random output word.
- Lanes are 32/64/128/256 bits, selected per job by `width_t`; carries are killed at lane boundaries.
- Sits between the PRNG expander and the CR output FIFO.
- Successor to the fixed 256-bit, 32-bit-limb carry-mask arithmetic: generalised in data width, limb width and count width, and adds a subtract mode and a job FSM.

Parameters:
- DATA_W, 256, accumulator/data width in bits; multiple of LIMB_W.
- LIMB_W, 32, limb width; minimum lane granularity.
- CNT_W, 32, width of the word-count field.
- NLIMB, DATA_W/LIMB_W, derived; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  job start pulse; accepted only in IDLE.
- width_i  in  3  width_t {is256,is128,is64}; latched at start.
- sub_i  in  1  0 = acc += word, 1 = acc -= word per lane; latched at start.
- num_words_i  in  CNT_W  words to consume this job; latched at start.
- busy_o  out  1  high when not IDLE.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  high only in ACC.
- in_data_i  in  DATA_W  PRNG word.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accept.
- out_data_o  out  DATA_W  accumulated result.
- words_done_o  out  CNT_W  words consumed in the current job.

Behaviour:
- Reset (async, any state): FSM to IDLE. acc, words_done_o, out_data_o, out_valid_o, in_ready_o, busy_o all 0. Any in-flight job is discarded; no partial output.
- Width decode, priority is256 > is128 > is64 > 32-bit:
  - 256-bit mode: no carry kills.
  - 128-bit mode: kill at limb NLIMB/2.
  - 64-bit mode: kill at every even limb.
  - 32-bit mode: kill at all limb boundaries.
  - Encodings such as 0b010 therefore decode to 128-bit mode.
  - Carry out of the top limb of each lane is discarded; arithmetic is modulo 2^lane.
- Per-limb arithmetic uses u32_w_c_t:
  - Add: limb_sum = acc_limb + word_limb + cin.
  - Subtract: limb_sum = acc_limb + ~word_limb + cin, where cin is forced to 1 at every lane-start limb.
  - cin for limb 0 is always the lane-start value.
- FSM IDLE -> ACC -> OUT -> IDLE.
  - IDLE: on start_i, latch width/sub/num, clear acc and words_done.
    - If num_words_i == 0, go directly to OUT with result 0.
    - Otherwise go to ACC.
    - start_i in any other state is ignored.
  - ACC: in_ready_o = 1.
    - Each cycle with in_valid_i & in_ready_o, acc <= f(acc, in_data_i) in the same cycle and words_done increments.
    - When the incremented count equals the latched num: go to OUT; out_data_o <= new acc; out_valid_o <= 1. in_ready_o drops the next cycle.
    - Throughput: 1 word/cycle.
  - OUT: out_valid_o held with out_data_o stable until out_ready_i.
    - On handshake, out_valid_o <= 0 and go to IDLE. busy_o low from the next cycle.
    - start_i in the handshake cycle is ignored.
- Latency: result is valid the cycle after the last input handshake.
- Changes on width_i, sub_i or num_words_i after start have no effect.
- num = 2^CNT_W - 1 is a legal job; the counter must not wrap before matching.

Decomposition:
- Shared package (extends TYPES):
  - width_t and u32_w_c_t reused.
  - Add acc_state_t enum {IDLE, ACC, OUT}.
  - Add a parametrised lane_kill mask function: width_t -> NLIMB-bit vector of kill points, generalising make_carry_mask.
- One sub-module, cr_lane_addsub: purely combinational DATA_W segmented adder/subtractor. Inputs: a, b, width, sub. Output: sum. Limb ripple uses the kill mask. Reused by future CR blocks.

Test Plan:
- 256-bit add:
  - Stimulus: width=0b111, sub=0, num=2; words 2^255, then 2^255 + 5.
  - Required: out = 5, with the 2^256 carry dropped.
- 32-bit add:
  - Stimulus: width=0b000, num=1 after a reset (acc starts at 0).
  - Then a second job: num=2; words all-limbs 0xFFFFFFFF, then all-limbs 1.
  - Required: every limb = 0; no cross-limb carry.
- 64-bit subtract:
  - Stimulus: width=0b001, sub=1, num=1; word with each 64-bit lane = 1.
  - Required: each lane = 0xFFFFFFFFFFFFFFFF; limb pairs are independent.
- num=0:
  - Stimulus: start with num=0.
  - Required: out_valid next cycle, data 0, in_ready never asserted.
- Backpressure and bubbles:
  - Stimulus: num=3, in_valid bubbles between words, out_ready held low 5 cycles.
  - Required: out_data stable and out_valid high for all 5 cycles; words_done = 3; busy drops the cycle after the handshake.
- Reset mid-job:
  - Stimulus: assert rst after 1 of 4 words.
  - Required: all outputs 0 immediately (asynchronous). A new start with num=1 and word 7 yields 7.
